fx2_wr_sched: RTL
=================

# fx2_wr_sched

Write scheduler for the FX2 slave-FIFO port in the `ifclk_i` domain. It sits between the read side of the capture `fifo_sync` and the FX2 pins. It shares the single 16-bit write bus among the capture stream, an occasional status word and the built-in test-pattern generator. It also decides when to commit a short packet with PKTEND, either on an explicit flush request or after an idle timeout.

## Interface
Parameters:
- `W`, 16, data bus width.
- `PKT_WORDS`, 256, words per FX2 packet (512 bytes); power of two.
- `IDLE_TIMEOUT`, 1024, idle cycles with a partial packet before an automatic flush; ≥2.

Ports:
- `clk_i`  in  1  FX2 interface clock (`ifclk_i` at top level).
- `reset_i`  in  1  asynchronous, active-high reset.
- `test_i`  in  1  test-pattern mode request (level, already synchronized to `clk_i`).
- `flush_i`  in  1  single-cycle pulse requesting a short-packet commit.
- `full_i`  in  1  FX2 FIFO full flag (FLAGB), active-high.
- `str_data_i`  in  W  capture stream word.
- `str_valid_i`  in  1  stream word available.
- `str_ready_o`  out  1  stream word consumed this cycle.
- `sts_data_i`  in  W  status word.
- `sts_req_i`  in  1  status write request (level).
- `sts_ack_o`  out  1  status word written this cycle.
- `slwr_o`  out  1  FX2 write strobe, active-high.
- `pktend_o`  out  1  FX2 packet end, active-high.
- `fd_o`  out  W  FX2 data bus.
- `wcnt_o`  out  log2(PKT_WORDS)  words in the current packet.

## Operation
- States: `STREAM`, `FLUSH`, `TEST`. Reset state is `STREAM`.
- Counters and registers: word counter `wcnt`, idle counter `idle`, `flush_pend` flag, 16-bit `lfsr`.

STREAM, on each cycle with `!full_i`:
- If `sts_req_i`: write `sts_data_i` and assert `sts_ack_o`. Status has priority over the stream.
- Else if `str_valid_i`: write `str_data_i` and assert `str_ready_o`.
- Else: no write.

Word counting:
- Each write increments `wcnt` modulo `PKT_WORDS`.
- A wrap to 0 means the FX2 auto-committed the packet; no PKTEND is issued.

Flush and idle:
- `flush_i` sets `flush_pend`.
- `idle` increments on each non-write cycle while `wcnt != 0`. It clears on any write and whenever `wcnt == 0`.
- When `idle` reaches `IDLE_TIMEOUT - 1`, `flush_pend` is set.

Transitions out of STREAM:
- If `flush_pend` and `wcnt == 0`: clear `flush_pend`. No zero-length packets are sent.
- If `flush_pend` and `wcnt != 0`: go to FLUSH. The write that may occur in that same cycle still counts.
- Else if `test_i` and no write this cycle: go to TEST.

FLUSH:
- No writes; both acks low.
- When `!full_i`: assert `pktend_o` for that cycle, clear `wcnt`, `idle` and `flush_pend`, then go to STREAM.

TEST:
- Each cycle with `!full_i`: `slwr_o = 1`, `fd_o = lfsr`, and `lfsr <= rng_next(lfsr)`.
- Stream and status are never acked. `pktend_o` stays 0. `flush_i` is ignored and `flush_pend` is cleared.
- When `test_i` drops: go to STREAM and clear `wcnt`.

LFSR:
- Outside TEST, `lfsr` is held at `rng_next(16'h6c41) = 16'hABE7`.
- `rng_next` is the xorshift16 with shifts (<<7, >>9, <<8).

Combined events:
- `flush_i` in the cycle that wraps `wcnt` to 0: the flush is dropped.
- `test_i` rising during FLUSH: the PKTEND completes first.
- `flush_i` and `sts_req_i` together: the status word is written first.

## Timing
- `slwr_o`, `pktend_o`, `fd_o`, `str_ready_o` and `sts_ack_o` are combinational from state and current inputs. There is zero latency from `full_i` falling to a write.
- `full_i` high forces `slwr_o = 0` and `pktend_o = 0` in the same cycle.
- `slwr_o` and `pktend_o` are never high in the same cycle.
- `fd_o` is 0 in cycles with no write.
- Handshakes:
  - Stream: producer holds `str_data_i` and `str_valid_i` until `str_ready_o`.
  - Status: requester holds `sts_req_i` until `sts_ack_o`, then deasserts within one cycle.
- Throughput: one word per cycle.
- Flush latency: `flush_i` to PKTEND is 2 cycles minimum (pending, FLUSH), longer while full.
- Reset: asynchronous assert clears everything immediately:
  - all outputs 0; `wcnt`, `idle` and `flush_pend` 0; state STREAM; `lfsr = 16'hABE7`.
  - A reset mid-FLUSH drops the PKTEND.
- Release is synchronous to `clk_i`.

## Structure
- Shared package `usb_sniffer_pkg`: the `rng_next` function, the `16'h6c41` seed and the state encoding. The top-level test generator uses the same package.
- Sub-module `fx2_test_lfsr`: `clk_i`, `reset_i`, `load_i`, `step_i`, `data_o`.
- Arbitration, counters and FSM stay in `fx2_wr_sched`.

## Test plan
- **Stream:** 300 continuous stream words (0x0000..0x012B), `full_i = 0` → 300 `slwr_o` cycles with matching `fd_o`, no `pktend_o`, `wcnt_o` ends at 44.
- **Status priority and full stall:**
  - Stream valid and `sts_req_i` (`sts_data_i = 16'hA55A`) together → the first write is `A55A` with `sts_ack_o`, the stream resumes next cycle.
  - `full_i` high for 5 cycles → no strobes, data held.
- **Flush:**
  - Write 3 words, pulse `flush_i` → exactly one `pktend_o` 2 cycles later, `wcnt_o = 0`.
  - Flush with `wcnt = 0` → no `pktend_o`.
- **Idle timeout:** `IDLE_TIMEOUT = 8`, write 1 word then idle → `pktend_o` once, about 9 cycles later; no further `pktend_o`.
- **Test mode:** raise `test_i` → first word `16'hABE7`, subsequent words follow `rng_next`; `full_i` pauses the sequence without skipping values; stream is never acked.
- **Reset:** assert `reset_i` mid-FLUSH with `full_i` high → all outputs 0 immediately; after release a write starts at `wcnt_o = 0`.

Source files
------------

// File: rtl/usb_sniffer_pkg.sv
// usb_sniffer_pkg: definitions shared by the FX2 write path.
//   wr_state_t - write scheduler state encoding (STREAM / FLUSH / TEST)
//   RNG_SEED   - seed of the test-pattern generator
//   LFSR_INIT  - first test word, rng_next(RNG_SEED) = 16'hABE7
//   rng_next() - xorshift16 step with shifts (<<7, >>9, <<8)
package usb_sniffer_pkg;

  typedef enum logic [1:0] {
    ST_STREAM = 2'd0,
    ST_FLUSH  = 2'd1,
    ST_TEST   = 2'd2
  } wr_state_t;

  localparam logic [15:0] RNG_SEED = 16'h6c41;

  function automatic logic [15:0] rng_next(input logic [15:0] x);
    logic [15:0] y;
    y = x ^ (x << 7);
    y = y ^ (y >> 9);
    y = y ^ (y << 8);
    return y;
  endfunction

  localparam logic [15:0] LFSR_INIT = rng_next(RNG_SEED);

endpackage

// File: rtl/fx2_test_lfsr.sv
// fx2_test_lfsr: test-pattern word generator for the FX2 write path.
//   clk_i   - interface clock
//   reset_i - asynchronous active-high reset, returns data_o to LFSR_INIT
//   load_i  - hold the generator at LFSR_INIT (used outside test mode)
//   step_i  - advance one xorshift16 step (a test word was just written)
//   data_o  - current test word
module fx2_test_lfsr
  import usb_sniffer_pkg::*;
(
  input  logic        clk_i,
  input  logic        reset_i,
  input  logic        load_i,
  input  logic        step_i,
  output logic [15:0] data_o
);

  logic [15:0] lfsr_reg;

  always_ff @(posedge clk_i or posedge reset_i) begin
    if (reset_i) begin
      lfsr_reg <= LFSR_INIT;
    end else if (load_i) begin
      lfsr_reg <= LFSR_INIT;
    end else if (step_i) begin
      lfsr_reg <= rng_next(lfsr_reg);
    end
  end

  assign data_o = lfsr_reg;

endmodule

// File: rtl/fx2_wr_sched.sv
// fx2_wr_sched: write scheduler for the FX2 slave-FIFO port.
// Shares the FX2 write bus between the capture stream, a status word
// (higher priority) and the test-pattern generator, and decides when to
// commit a short packet with PKTEND (explicit flush or idle timeout).
//   clk_i        - FX2 interface clock
//   reset_i      - asynchronous active-high reset
//   test_i       - test-pattern mode request (level)
//   flush_i      - one-cycle short-packet commit request
//   full_i       - FX2 FIFO full flag
//   str_data_i / str_valid_i / str_ready_o - capture stream handshake
//   sts_data_i / sts_req_i / sts_ack_o     - status word handshake
//   slwr_o, pktend_o, fd_o                 - FX2 write strobe, packet end, data
//   wcnt_o       - words in the current packet
module fx2_wr_sched
  import usb_sniffer_pkg::*;
#(
  parameter int W            = 16,
  parameter int PKT_WORDS    = 256,
  parameter int IDLE_TIMEOUT = 1024
) (
  input  logic                         clk_i,
  input  logic                         reset_i,
  input  logic                         test_i,
  input  logic                         flush_i,
  input  logic                         full_i,
  input  logic [W-1:0]                 str_data_i,
  input  logic                         str_valid_i,
  output logic                         str_ready_o,
  input  logic [W-1:0]                 sts_data_i,
  input  logic                         sts_req_i,
  output logic                         sts_ack_o,
  output logic                         slwr_o,
  output logic                         pktend_o,
  output logic [W-1:0]                 fd_o,
  output logic [$clog2(PKT_WORDS)-1:0] wcnt_o
);

  localparam int CW = $clog2(PKT_WORDS);
  localparam int IW = $clog2(IDLE_TIMEOUT) + 1;
  // idle_reg holds this value in the cycle that brings it to IDLE_TIMEOUT-1
  localparam logic [IW-1:0] IDLE_LAST = IW'(IDLE_TIMEOUT - 2);

  wr_state_t     state_reg;
  logic [CW-1:0] wcnt_reg;
  logic [CW-1:0] wcnt_next;
  logic [IW-1:0] idle_reg;
  logic          flush_pend_reg;
  logic [15:0]   lfsr_q;

  logic sts_wr;
  logic str_wr;
  logic test_wr;
  logic pkt_end;
  logic any_wr;
  logic idle_hit;

  // Write/commit decode for the current cycle; purely combinational so a
  // falling full flag produces a write in the same cycle.
  always_comb begin
    sts_wr  = 1'b0;
    str_wr  = 1'b0;
    test_wr = 1'b0;
    pkt_end = 1'b0;
    case (state_reg)
      ST_STREAM: begin
        if (!full_i) begin
          if (sts_req_i)        sts_wr = 1'b1;
          else if (str_valid_i) str_wr = 1'b1;
        end
      end
      ST_FLUSH: pkt_end = !full_i;
      ST_TEST:  test_wr = !full_i;
      default: ;
    endcase
  end

  assign any_wr    = sts_wr | str_wr | test_wr;
  assign wcnt_next = wcnt_reg + CW'(any_wr);
  assign idle_hit  = !any_wr && (wcnt_reg != '0) && (idle_reg == IDLE_LAST);

  // Outputs are gated by reset so they read 0 while reset is held, even
  // with live requests on the inputs.
  always_comb begin
    str_ready_o = str_wr & ~reset_i;
    sts_ack_o   = sts_wr & ~reset_i;
    slwr_o      = any_wr & ~reset_i;
    pktend_o    = pkt_end & ~reset_i;
    fd_o        = '0;
    if (!reset_i) begin
      if (sts_wr)       fd_o = sts_data_i;
      else if (str_wr)  fd_o = str_data_i;
      else if (test_wr) fd_o = W'(lfsr_q);
    end
  end

  assign wcnt_o = wcnt_reg;

  always_ff @(posedge clk_i or posedge reset_i) begin
    if (reset_i) begin
      state_reg      <= ST_STREAM;
      wcnt_reg       <= '0;
      idle_reg       <= '0;
      flush_pend_reg <= 1'b0;
    end else begin
      case (state_reg)
        ST_STREAM: begin
          wcnt_reg <= wcnt_next;
          if (any_wr || wcnt_reg == '0) idle_reg <= '0;
          else                          idle_reg <= idle_reg + 1'b1;
          if (flush_pend_reg) begin
            // Nothing to commit: either the packet is empty or this
            // cycle's write fills it and the FX2 commits it on its own.
            if (wcnt_reg == '0 || wcnt_next == '0) flush_pend_reg <= 1'b0;
            else                                   state_reg      <= ST_FLUSH;
          end else begin
            if (flush_i || idle_hit) flush_pend_reg <= 1'b1;
            if (test_i && !any_wr)   state_reg      <= ST_TEST;
          end
        end
        ST_FLUSH: begin
          if (!full_i) begin
            state_reg      <= ST_STREAM;
            wcnt_reg       <= '0;
            idle_reg       <= '0;
            flush_pend_reg <= 1'b0;
          end
        end
        ST_TEST: begin
          idle_reg       <= '0;
          flush_pend_reg <= 1'b0;
          if (!test_i) begin
            state_reg <= ST_STREAM;
            wcnt_reg  <= '0;
          end else begin
            wcnt_reg <= wcnt_next;
          end
        end
        default: state_reg <= ST_STREAM;
      endcase
    end
  end

  fx2_test_lfsr u_lfsr (
    .clk_i   (clk_i),
    .reset_i (reset_i),
    .load_i  (state_reg != ST_TEST),
    .step_i  (test_wr),
    .data_o  (lfsr_q)
  );

endmodule
